skid_pipeline_reg: RTL and testbench
====================================

SKID_PIPELINE_REG -- requirements
Module: skid_pipeline_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload bit width, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 2: number of cascaded skid stages, legal range 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all held items.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream item present.
REQ-007 SHALL have port in_ready, output, 1 bit: stage 0 can accept.
REQ-008 SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: last stage holds an item.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-011 SHALL have port out_data, output, WIDTH bits: downstream payload.
REQ-012 SHALL have port occupancy, output, $clog2(2*DEPTH+1) bits: items held, range 0..2*DEPTH.

Function
REQ-013 A transfer SHALL occur on a port only in a cycle where valid and ready are both high at the clock edge.
REQ-014 Each stage SHALL hold a main register and a skid register, giving 2 entries per stage.
REQ-015 Each stage's upstream ready SHALL be the inverse of its skid-valid flag, registered, so there is no combinational ready path across stages.
REQ-016 Each stage's downstream valid and data SHALL come straight from its main register, so there is no combinational path from in_* to out_*.
REQ-017 Stage accepts with main register empty, or main register draining that cycle: item SHALL go to the main register.
REQ-018 Stage accepts with main register full and not draining: item SHALL go to the skid register; skid_valid SHALL set.
REQ-019 When main drains and skid is valid: skid contents SHALL move to main; skid_valid SHALL clear.
REQ-020 Latency with out_ready held high SHALL be exactly DEPTH cycles from an in_* transfer to that item on out_*.
REQ-021 Throughput with out_ready held high SHALL be 1 item per cycle, with no bubbles.
REQ-022 Items SHALL leave in acceptance order, with no loss or duplication.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-024 in_valid may drop without in_ready; an item not transferred SHALL NOT be captured.
REQ-025 occupancy SHALL equal the count of set main-valid and skid-valid flags.
REQ-026 occupancy SHALL be registered, and SHALL update by +1, -1, or 0 when an in and an out transfer coincide.
REQ-027 Full (occupancy = 2*DEPTH): in_ready SHALL be 0.
REQ-028 Empty (occupancy = 0): out_valid SHALL be 0.
REQ-029 in_ready SHALL be forced to 0 during any cycle with flush=1.
REQ-030 flush=1 at an edge SHALL clear all valid flags and set occupancy to 0.
REQ-031 flush=1 SHALL override a coincident in transfer or out transfer at the same edge; nothing is accepted or retained.
REQ-032 Data registers SHALL NOT need clearing on flush or reset; only valid flags matter.

Reset
REQ-033 resetn=0 SHALL immediately clear all main-valid and skid-valid flags, regardless of clk.
REQ-034 During reset: out_valid=0, occupancy=0, in_ready=1 (unless flush=1).
REQ-035 Reset asserted mid-transfer SHALL discard all held items.
REQ-036 After release, the first edge SHALL be able to accept an item.

Structure
REQ-037 Sub-module skid_buffer_stage SHALL implement one 2-entry stage with parameter WIDTH and ports clk, resetn, flush, in and out handshake.
REQ-038 The top SHALL instantiate DEPTH skid_buffer_stage instances via generate, chained valid/ready/data.
REQ-039 The top SHALL own the occupancy counter.
REQ-040 A shared package SHALL hold: occupancy-width function $clog2(2*DEPTH+1), default WIDTH=32, default DEPTH=2.
REQ-041 Total RTL SHALL be about 150-250 lines.

Verification (WIDTH=32, DEPTH=3)
REQ-042 Latency: out_ready=1, send 43 -> out_valid=1 with out_data=43 exactly 3 cycles later; occupancy returns to 0.
REQ-043 Streaming: out_ready=1, send 1..10 back-to-back -> 10 consecutive outputs 1..10 with no gap; in_ready never drops.
REQ-044 Backpressure: out_ready=0, send 1..7 -> exactly 6 accepted, in_ready=0 and occupancy=6 while full, out_data=1 stable; then out_ready=1 -> 1..6 in order.
REQ-045 Simultaneous: occupancy=4, in and out transfer on the same edge -> occupancy stays 4, order preserved.
REQ-046 Flush: occupancy=5, flush=1 with in_valid=1 on one edge -> next cycle occupancy=0, out_valid=0, new item not captured; the following item 99 emerges 3 cycles later.
REQ-047 Reset: assert resetn=0 with occupancy=3, asynchronously between edges -> out_valid=0 and occupancy=0 before the next edge; resume with 55 -> 55 out after 3 cycles.

Source files
------------

// File: rtl/skid_pipeline_reg_pkg.sv
// Shared defaults and sizing helper for the skid pipeline register.
package skid_pipeline_reg_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 2;

  // Width needed to count 0..2*depth held items.
  function automatic int unsigned occ_width(int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_buffer_stage.sv
// One 2-entry skid stage: a main register feeding downstream and a skid register that
// catches the item arriving while main is stalled. Upstream ready depends only on state.
module skid_buffer_stage
  import skid_pipeline_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  assign in_fire  = in_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & out_ready;

  // Next-state: refill main from skid first, then from upstream; overflow goes to skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        // in_fire cannot coincide here because ready is low while skid is held.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Valid flags: the only state that reset has to clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers: meaningless while their valid flag is clear, so no reset.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/skid_pipeline_reg.sv
// Cascade of DEPTH skid stages with a registered occupancy count and synchronous flush.
module skid_pipeline_reg
  import skid_pipeline_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  // Element i is the input side of stage i; element DEPTH is the pipeline output.
  logic             valid_chain [DEPTH+1];
  logic             ready_chain [DEPTH+1];
  logic [WIDTH-1:0] data_chain  [DEPTH+1];

  logic            in_xfer;
  logic            out_xfer;
  logic [OccW-1:0] occ_q, occ_d;

  assign valid_chain[0]     = in_valid;
  assign data_chain[0]      = in_data;
  assign ready_chain[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    skid_buffer_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .in_valid (valid_chain[i]),
      .in_ready (ready_chain[i]),
      .in_data  (data_chain[i]),
      .out_valid(valid_chain[i+1]),
      .out_ready(ready_chain[i+1]),
      .out_data (data_chain[i+1])
    );
  end

  // Flush wins over any coincident transfer, so ready is masked here.
  assign in_ready  = ready_chain[0] & ~flush;
  assign out_valid = valid_chain[DEPTH];
  assign out_data  = data_chain[DEPTH];
  assign occupancy = occ_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy next-state: net of this cycle's transfers, zero on flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OccW'(in_xfer) - OccW'(out_xfer);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_skid_pipeline_reg.sv
// Directed bench for skid_pipeline_reg with WIDTH=32, DEPTH=3.
module tb_skid_pipeline_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       occupancy;

  int checks;
  int errors;

  skid_pipeline_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    int got;
    logic [31:0] want;

    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Latency: 43 appears exactly 3 cycles after its transfer
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd43;
    #1;
    chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lat_occ1", {29'd0, occupancy}, 32'd1);
    chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_c2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_c3_data", out_data, 32'd43);
    tick();
    chk("lat_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_drain_occ", {29'd0, occupancy}, 32'd0);

    // Streaming 1..10 back-to-back with out_ready high
    for (int k = 0; k < 13; k++) begin
      in_valid = (k < 10);
      in_data  = 32'(k + 1);
      if (k < 10) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("stream_out_valid", {31'd0, out_valid}, (k >= 2 && k <= 11) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 11) chk("stream_out_data", out_data, 32'(k - 1));
    end
    in_valid = 1'b0;
    chk("stream_end_occ", {29'd0, occupancy}, 32'd0);

    // Backpressure: 1..7 offered, only 6 fit
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      if (in_ready) accepted++;
      tick();
    end
    chk("bp_accepted", 32'(accepted), 32'd6);
    for (int i = 0; i < 2; i++) begin
      chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_full_occ", {29'd0, occupancy}, 32'd6);
      chk("bp_stable_data", out_data, 32'd1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got       = 0;
    want      = 32'd1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        chk("bp_drain_data", out_data, want);
        want++;
        got++;
      end
      tick();
    end
    chk("bp_drain_count", 32'(got), 32'd6);
    chk("bp_drain_occ", {29'd0, occupancy}, 32'd0);

    // Simultaneous in and out transfer at occupancy 4
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(100 + i);
      tick();
    end
    chk("sim_occ_before", {29'd0, occupancy}, 32'd4);
    chk("sim_head", out_data, 32'd100);
    chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    in_data   = 32'd104;
    tick();
    in_valid = 1'b0;
    chk("sim_occ_after", {29'd0, occupancy}, 32'd4);
    got  = 0;
    want = 32'd101;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        chk("sim_drain_data", out_data, want);
        want++;
        got++;
      end
      tick();
    end
    chk("sim_drain_count", 32'(got), 32'd4);

    // Flush at occupancy 5 with a coincident offer and an out transfer
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(200 + i);
      tick();
    end
    chk("fl_occ_before", {29'd0, occupancy}, 32'd5);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'd77;
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ_after", {29'd0, occupancy}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'd99;
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_c2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("fl_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_c3_data", out_data, 32'd99);
    tick();
    chk("fl_end_occ", {29'd0, occupancy}, 32'd0);

    // Asynchronous reset mid-cycle at occupancy 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(300 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("rs_occ_before", {29'd0, occupancy}, 32'd3);
    chk("rs_valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_occ", {29'd0, occupancy}, 32'd0);
    chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd55;
    tick();
    in_valid = 1'b0;
    chk("rs_resume_occ", {29'd0, occupancy}, 32'd1);
    tick();
    chk("rs_c2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rs_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("rs_c3_data", out_data, 32'd55);
    tick();
    chk("rs_end_occ", {29'd0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
